// File: rtl/uart_bus_bridge_pkg.sv
// Shared definitions for the UART-to-bus bridge: command opcodes, response
// codes and the parser/transmit state encoding.
package uart_bus_bridge_pkg;

  localparam logic [7:0] OP_WRITE    = 8'h01;
  localparam logic [7:0] OP_READ     = 8'h02;
  localparam logic [7:0] RESP_WR_OK  = 8'hA5;
  localparam logic [7:0] RESP_BAD_OP = 8'hEE;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_EXEC_W,
    ST_EXEC_R,
    ST_CAPTURE,
    ST_SEND,
    ST_SEND_HOLD,
    ST_SEND_WAIT
  } state_e;

endpackage

// File: rtl/uart_bus_bridge_byte_timeout.sv
// byte_timeout: loadable saturating up-counter used as the inter-byte timer.
// Ports:
//   clk, rst_n  clock and async active-low reset
//   clear       restart the count from zero (a byte arrived)
//   enable      count this cycle (parser is mid-command)
//   expired     high while enabled and the count sits at TIMEOUT; the
//               parser leaves its counting states on this, so it acts as a
//               single-cycle pulse
module uart_bus_bridge_byte_timeout #(
  parameter int TIMEOUT  = 1200000,
  parameter int TO_WIDTH = 21
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam logic [TO_WIDTH-1:0] TERM = TO_WIDTH'(TIMEOUT);

  logic [TO_WIDTH-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear) begin
      count_d = '0;
    end else if (enable && (count_q != TERM)) begin
      count_d = count_q + TO_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  // A byte arriving in the expiry cycle wins: clear masks the expiry.
  assign expired = enable && !clear && (count_q == TERM);

endmodule

// File: rtl/uart_bus_bridge.sv
// uart_bus_bridge: parses byte-framed read/write commands from a UART
// receiver, drives a 16-bit bus, and returns response bytes to a UART
// transmitter.
// Ports:
//   CLK, RSTN           clock, async active-low reset
//   RXbuffer, RXready   received byte and its one-cycle valid pulse
//   TXbuffer, TXstart   byte to send and its one-cycle request
//   TXbusy              transmitter busy
//   busAddr, busDout    bus address / write data (held between commands)
//   busDin              read data, valid the cycle after busRead
//   busWrite, busRead   one-cycle bus strobes
//   busy                high whenever the FSM is not idle
//   overrun             sticky: a byte was dropped while executing/responding
//
// state       | meaning
// ------------+--------------------------------------------------------
// IDLE        | waiting for an opcode byte
// ADDR_H      | waiting for address high byte
// ADDR_L      | waiting for address low byte
// DATA_H      | waiting for write data high byte
// DATA_L      | waiting for write data low byte
// EXEC_W      | busWrite strobe cycle
// EXEC_R      | busRead strobe cycle
// CAPTURE     | latch busDin, queue the two read response bytes
// SEND        | raise TXstart once the transmitter is free
// SEND_HOLD   | TXstart cycle; TXbusy not yet meaningful
// SEND_WAIT   | wait for TXbusy low, then next byte or IDLE
module uart_bus_bridge
  import uart_bus_bridge_pkg::*;
#(
  parameter int TIMEOUT  = 1200000,
  parameter int TO_WIDTH = 21
) (
  input  logic        CLK,
  input  logic        RSTN,
  input  logic [7:0]  RXbuffer,
  input  logic        RXready,
  output logic [7:0]  TXbuffer,
  output logic        TXstart,
  input  logic        TXbusy,
  output logic [15:0] busAddr,
  output logic [15:0] busDout,
  input  logic [15:0] busDin,
  output logic        busWrite,
  output logic        busRead,
  output logic        busy,
  output logic        overrun
);

  state_e      state_q, state_d;
  logic [15:0] cmd_addr_q, cmd_addr_d;
  logic [7:0]  data_hi_q, data_hi_d;
  logic        is_write_q, is_write_d;
  logic [7:0]  tx_buf_q, tx_buf_d;
  logic [7:0]  tx_next_q, tx_next_d;
  logic        tx_more_q, tx_more_d;
  logic        tx_start_q, tx_start_d;
  logic [15:0] bus_addr_q, bus_addr_d;
  logic [15:0] bus_dout_q, bus_dout_d;
  logic        bus_write_q, bus_write_d;
  logic        bus_read_q, bus_read_d;
  logic        busy_q, busy_d;
  logic        overrun_q, overrun_d;

  logic to_enable;
  logic to_expired;

  assign to_enable = state_q inside {ST_ADDR_H, ST_ADDR_L, ST_DATA_H, ST_DATA_L};

  uart_bus_bridge_byte_timeout #(
    .TIMEOUT (TIMEOUT),
    .TO_WIDTH(TO_WIDTH)
  ) u_byte_timeout (
    .clk    (CLK),
    .rst_n  (RSTN),
    .clear  (RXready),
    .enable (to_enable),
    .expired(to_expired)
  );

  always_comb begin
    state_d     = state_q;
    cmd_addr_d  = cmd_addr_q;
    data_hi_d   = data_hi_q;
    is_write_d  = is_write_q;
    tx_buf_d    = tx_buf_q;
    tx_next_d   = tx_next_q;
    tx_more_d   = tx_more_q;
    tx_start_d  = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_dout_d  = bus_dout_q;
    bus_write_d = 1'b0;
    bus_read_d  = 1'b0;
    overrun_d   = overrun_q;

    case (state_q)
      ST_IDLE: begin
        if (RXready) begin
          if ((RXbuffer == OP_WRITE) || (RXbuffer == OP_READ)) begin
            is_write_d = (RXbuffer == OP_WRITE);
            state_d    = ST_ADDR_H;
          end else begin
            tx_buf_d  = RESP_BAD_OP;
            tx_more_d = 1'b0;
            state_d   = ST_SEND;
          end
        end
      end
      ST_ADDR_H: begin
        if (RXready) begin
          cmd_addr_d[15:8] = RXbuffer;
          state_d          = ST_ADDR_L;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_ADDR_L: begin
        if (RXready) begin
          cmd_addr_d[7:0] = RXbuffer;
          if (is_write_q) begin
            state_d = ST_DATA_H;
          end else begin
            // Strobe registered here so it lands the cycle after the last byte.
            bus_addr_d = {cmd_addr_q[15:8], RXbuffer};
            bus_read_d = 1'b1;
            state_d    = ST_EXEC_R;
          end
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_H: begin
        if (RXready) begin
          data_hi_d = RXbuffer;
          state_d   = ST_DATA_L;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_DATA_L: begin
        if (RXready) begin
          bus_addr_d  = cmd_addr_q;
          bus_dout_d  = {data_hi_q, RXbuffer};
          bus_write_d = 1'b1;
          state_d     = ST_EXEC_W;
        end else if (to_expired) begin
          state_d = ST_IDLE;
        end
      end
      ST_EXEC_W: begin
        tx_buf_d  = RESP_WR_OK;
        tx_more_d = 1'b0;
        state_d   = ST_SEND;
      end
      ST_EXEC_R: begin
        state_d = ST_CAPTURE;
      end
      ST_CAPTURE: begin
        tx_buf_d  = busDin[15:8];
        tx_next_d = busDin[7:0];
        tx_more_d = 1'b1;
        state_d   = ST_SEND;
      end
      ST_SEND: begin
        if (!TXbusy) begin
          tx_start_d = 1'b1;
          state_d    = ST_SEND_HOLD;
        end
      end
      ST_SEND_HOLD: begin
        // The transmitter may not have raised TXbusy yet.
        state_d = ST_SEND_WAIT;
      end
      ST_SEND_WAIT: begin
        if (!TXbusy) begin
          if (tx_more_q) begin
            tx_buf_d  = tx_next_q;
            tx_more_d = 1'b0;
            state_d   = ST_SEND;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (RXready && (state_q inside {ST_EXEC_W, ST_EXEC_R, ST_CAPTURE,
                                    ST_SEND, ST_SEND_HOLD, ST_SEND_WAIT})) begin
      overrun_d = 1'b1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state_q     <= ST_IDLE;
      cmd_addr_q  <= '0;
      data_hi_q   <= '0;
      is_write_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_next_q   <= '0;
      tx_more_q   <= 1'b0;
      tx_start_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_dout_q  <= '0;
      bus_write_q <= 1'b0;
      bus_read_q  <= 1'b0;
      busy_q      <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_addr_q  <= cmd_addr_d;
      data_hi_q   <= data_hi_d;
      is_write_q  <= is_write_d;
      tx_buf_q    <= tx_buf_d;
      tx_next_q   <= tx_next_d;
      tx_more_q   <= tx_more_d;
      tx_start_q  <= tx_start_d;
      bus_addr_q  <= bus_addr_d;
      bus_dout_q  <= bus_dout_d;
      bus_write_q <= bus_write_d;
      bus_read_q  <= bus_read_d;
      busy_q      <= busy_d;
      overrun_q   <= overrun_d;
    end
  end

  assign TXbuffer = tx_buf_q;
  assign TXstart  = tx_start_q;
  assign busAddr  = bus_addr_q;
  assign busDout  = bus_dout_q;
  assign busWrite = bus_write_q;
  assign busRead  = bus_read_q;
  assign busy     = busy_q;
  assign overrun  = overrun_q;

endmodule

// File: tb/tb_uart_bus_bridge.sv
// Bench for uart_bus_bridge: command-level model of expected bus transactions
// and response bytes, a simple UART transmitter and bus memory, and one
// negedge compare process.
module tb_uart_bus_bridge;

  logic        CLK = 1'b0;
  logic        RSTN = 1'b0;
  logic [7:0]  RXbuffer = 8'h00;
  logic        RXready = 1'b0;
  logic [7:0]  TXbuffer;
  logic        TXstart;
  logic        TXbusy = 1'b0;
  logic [15:0] busAddr;
  logic [15:0] busDout;
  logic [15:0] busDin = 16'hDEAD;
  logic        busWrite;
  logic        busRead;
  logic        busy;
  logic        overrun;

  always #5 CLK = ~CLK;

  uart_bus_bridge #(.TIMEOUT(16), .TO_WIDTH(8)) dut (
    .CLK(CLK), .RSTN(RSTN),
    .RXbuffer(RXbuffer), .RXready(RXready),
    .TXbuffer(TXbuffer), .TXstart(TXstart), .TXbusy(TXbusy),
    .busAddr(busAddr), .busDout(busDout), .busDin(busDin),
    .busWrite(busWrite), .busRead(busRead),
    .busy(busy), .overrun(overrun)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  int cyc = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // ---------------- bus memory and model ----------------
  logic [15:0] mem [logic [15:0]];

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    return mem.exists(a) ? mem[a] : 16'h0000;
  endfunction

  logic [7:0]  exp_tx[$];
  logic [31:0] exp_wr[$];
  logic [15:0] exp_rd[$];
  logic [7:0]  cmd[$];
  int          exp_strobe_cyc = -1;

  task automatic model_rx(input logic [7:0] b);
    logic [15:0] a;
    logic [15:0] d;
    cmd.push_back(b);
    if (cmd[0] != 8'h01 && cmd[0] != 8'h02) begin
      exp_tx.push_back(8'hEE);
      cmd.delete();
    end else if (cmd[0] == 8'h02 && cmd.size() == 3) begin
      a = {cmd[1], cmd[2]};
      d = mem_rd(a);
      exp_rd.push_back(a);
      exp_tx.push_back(d[15:8]);
      exp_tx.push_back(d[7:0]);
      exp_strobe_cyc = cyc + 1;
      cmd.delete();
    end else if (cmd[0] == 8'h01 && cmd.size() == 5) begin
      a = {cmd[1], cmd[2]};
      d = {cmd[3], cmd[4]};
      exp_wr.push_back({a, d});
      mem[a] = d;
      exp_tx.push_back(8'hA5);
      exp_strobe_cyc = cyc + 1;
      cmd.delete();
    end
  endtask

  // ---------------- bus read responder ----------------
  always @(posedge CLK) begin
    logic        rd;
    logic [15:0] a;
    rd = busRead;
    a  = busAddr;
    #1 busDin = rd ? mem_rd(a) : 16'hDEAD;
  end

  // ---------------- UART transmitter model ----------------
  int tx_left = 0;
  always @(posedge CLK) begin
    logic st;
    st = TXstart;
    #1;
    if (st) begin
      tx_left = 5;
      TXbusy  = 1'b1;
    end else if (tx_left > 0) begin
      tx_left--;
      if (tx_left == 0) TXbusy = 1'b0;
    end
  end

  // ---------------- compare process ----------------
  logic [7:0]  seen_tx[$];
  int          strobe_cnt = 0;
  logic [15:0] last_wr_addr = 16'h0, last_wr_data = 16'h0, last_rd_addr = 16'h0;
  logic        prev_txs = 1'b0;
  logic        tx_valid = 1'b0;
  logic [7:0]  held_tx = 8'h00;

  always @(negedge CLK) begin
    logic [31:0] e;
    if (!RSTN) begin
      prev_txs = 1'b0;
      tx_valid = 1'b0;
    end else begin
      if (busWrite) begin
        strobe_cnt++;
        last_wr_addr = busAddr;
        last_wr_data = busDout;
        check("wr_latency", cyc, exp_strobe_cyc);
        if (exp_wr.size() == 0) check("wr_unexpected", 32'd1, 32'd0);
        else begin
          e = exp_wr.pop_front();
          check("wr_addr", {16'h0, busAddr}, {16'h0, e[31:16]});
          check("wr_data", {16'h0, busDout}, {16'h0, e[15:0]});
        end
      end
      if (busRead) begin
        strobe_cnt++;
        last_rd_addr = busAddr;
        check("rd_latency", cyc, exp_strobe_cyc);
        if (exp_rd.size() == 0) check("rd_unexpected", 32'd1, 32'd0);
        else check("rd_addr", {16'h0, busAddr}, {16'h0, exp_rd.pop_front()});
      end
      if (TXstart) begin
        check("tx_gap", {31'h0, prev_txs}, 32'd0);
        seen_tx.push_back(TXbuffer);
        held_tx  = TXbuffer;
        tx_valid = 1'b1;
        if (exp_tx.size() == 0) check("tx_unexpected", {24'h0, TXbuffer}, 32'h100);
        else check("tx_byte", {24'h0, TXbuffer}, {24'h0, exp_tx.pop_front()});
      end else if (TXbusy && tx_valid) begin
        check("tx_stable", {24'h0, TXbuffer}, {24'h0, held_tx});
      end
      prev_txs = TXstart;
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit dropped);
    RXbuffer = b;
    RXready  = 1'b1;
    if (!dropped) model_rx(b);
    tick();
    RXready = 1'b0;
    tick();
    tick();
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((busy || TXbusy) && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("idle_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic wait_tx_count(input int target);
    int n;
    n = 0;
    while (seen_tx.size() < target && n < 300) begin
      tick();
      n++;
    end
    if (n >= 300) check("tx_wait_expired", 32'd1, 32'd0);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_bus"}, {busAddr, busDout}, 32'h0);
    check({tag, "_ctl"}, {19'h0, TXbuffer, TXstart, busWrite, busRead, busy, overrun}, 32'h0);
  endtask

  int sc;
  int k;

  initial begin
    mem[16'h0010] = 16'hCAFE;
    mem[16'h0000] = 16'h1357;

    RSTN = 1'b0;
    repeat (3) tick();
    check_all_zero("reset");
    RSTN = 1'b1;
    tick();

    // write 01 12 34 BE EF
    send_byte(8'h01, 0); send_byte(8'h12, 0); send_byte(8'h34, 0);
    send_byte(8'hBE, 0); send_byte(8'hEF, 0);
    wait_idle();
    check("w_addr_lit", {16'h0, last_wr_addr}, 32'h1234);
    check("w_data_lit", {16'h0, last_wr_data}, 32'hBEEF);
    check("w_resp_lit", {24'h0, seen_tx[0]}, 32'hA5);
    check("w_strobes", strobe_cnt, 1);

    // read 02 00 10 -> CA FE
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    wait_idle();
    check("r_hi_lit", {24'h0, seen_tx[1]}, 32'hCA);
    check("r_lo_lit", {24'h0, seen_tx[2]}, 32'hFE);
    check("r_busy_fell", {31'h0, busy}, 32'd0);
    check("r_hold_bus", {busAddr, busDout}, 32'h0010BEEF);

    // bad opcode
    sc = strobe_cnt;
    send_byte(8'h7F, 0);
    wait_idle();
    check("bad_resp_lit", {24'h0, seen_tx[3]}, 32'hEE);
    check("bad_no_strobe", strobe_cnt, sc);
    check("bad_idle", {31'h0, busy}, 32'd0);

    // timeout: partial write then silence
    k  = seen_tx.size();
    sc = strobe_cnt;
    send_byte(8'h01, 0); send_byte(8'h12, 0);
    repeat (20) tick();
    cmd.delete();
    check("to_no_resp", seen_tx.size(), k);
    check("to_no_strobe", strobe_cnt, sc);
    check("to_idle", {31'h0, busy}, 32'd0);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h00, 0);
    wait_idle();
    check("to_read_hi", {24'h0, seen_tx[k]}, 32'h13);
    check("to_read_lo", {24'h0, seen_tx[k+1]}, 32'h57);

    // top address, write then read back
    send_byte(8'h01, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    send_byte(8'h00, 0); send_byte(8'h42, 0);
    wait_idle();
    k = seen_tx.size();
    send_byte(8'h02, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    wait_idle();
    check("ffff_addr", {16'h0, last_rd_addr}, 32'hFFFF);
    check("ffff_data", {seen_tx[k], seen_tx[k+1]}, 16'h0042);

    // overrun: byte arrives during SEND_WAIT
    check("ovr_clear", {31'h0, overrun}, 32'd0);
    k = seen_tx.size();
    send_byte(8'h01, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    send_byte(8'h55, 0); send_byte(8'hAA, 0);
    wait_tx_count(k + 1);
    send_byte(8'h02, 1);
    check("ovr_set", {31'h0, overrun}, 32'd1);
    wait_idle();
    check("ovr_resp", {24'h0, seen_tx[k]}, 32'hA5);
    check("ovr_count", seen_tx.size(), k + 1);
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h20, 0);
    wait_idle();
    check("ovr_next_cmd", {seen_tx[k+1], seen_tx[k+2]}, 16'h55AA);
    check("ovr_sticky", {31'h0, overrun}, 32'd1);

    // reset during SEND_WAIT of a read
    k = seen_tx.size();
    send_byte(8'h02, 0); send_byte(8'h00, 0); send_byte(8'h10, 0);
    wait_tx_count(k + 1);
    RSTN = 1'b0;
    #1;
    check_all_zero("midreset");
    exp_tx.delete();
    exp_rd.delete();
    exp_wr.delete();
    cmd.delete();
    tick();
    tick();
    RSTN = 1'b1;
    k = seen_tx.size();
    repeat (30) tick();
    check("rst_no_tx", seen_tx.size(), k);
    check("rst_idle", {31'h0, busy}, 32'd0);

    // recovery
    send_byte(8'h02, 0); send_byte(8'hFF, 0); send_byte(8'hFF, 0);
    wait_idle();
    check("rec_data", {seen_tx[k], seen_tx[k+1]}, 16'h0042);

    check("exp_tx_drained", exp_tx.size(), 0);
    check("exp_wr_drained", exp_wr.size(), 0);
    check("exp_rd_drained", exp_rd.size(), 0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
